fp_adder_pipe: RTL and testbench



---
 rtl/fp_pkg.sv | 53 +++++
 rtl/fp_norm_round.sv | 100 ++++++++++
 rtl/fp_adder_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined minifloat adder: default format,
// field-unpacking helpers and the align-to-add stage record.
package fp_pkg;

  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 3;

  // Stage records are sized for the widest legal format; narrower formats
  // keep their values right-aligned with the upper bits at zero.
  localparam int MAX_EXP_W = 5;
  localparam int MAX_MAN_W = 4;
  localparam int MAX_EXT_W = MAX_MAN_W + 4;
  localparam int WORD_W    = 16;

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp;
    logic [MAX_EXT_W-1:0] mant_big;
    logic [MAX_EXT_W-1:0] mant_small_ext;
    logic                 eff_sub;
  } align_t;

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp_fld;
    logic [MAX_MAN_W-1:0] man_fld;
    logic [MAX_MAN_W:0]   sig;
    logic [MAX_EXP_W-1:0] eff_exp;
  } fields_t;

  // Subnormals (exp == 0) get hidden bit 0 and effective exponent 1.
  function automatic fields_t unpack(input logic [WORD_W-1:0] word,
                                     input int exp_w, input int man_w);
    fields_t          f;
    logic [WORD_W-1:0] man_mask;
    logic [WORD_W-1:0] exp_mask;
    logic             hidden;
    man_mask  = WORD_W'((1 << man_w) - 1);
    exp_mask  = WORD_W'((1 << exp_w) - 1);
    f.sign    = word[4'(exp_w + man_w)];
    f.man_fld = MAX_MAN_W'(word & man_mask);
    f.exp_fld = MAX_EXP_W'((word >> man_w) & exp_mask);
    hidden    = (f.exp_fld != '0);
    f.sig     = (MAX_MAN_W+1)'(f.man_fld) | ((MAX_MAN_W+1)'(hidden) << man_w);
    f.eff_exp = hidden ? f.exp_fld : MAX_EXP_W'(1);
    return f;
  endfunction

  function automatic logic [WORD_W-1:0] max_finite(input int exp_w, input int man_w);
    return WORD_W'((1 << (exp_w + man_w)) - 1);
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalise/round for the adder's last stage: leading-zero
// count, exponent-limited left shift, round-to-nearest-even and saturation.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W+4:0] sum_i,
  output logic [W-1:0]     res_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             inx_o
);

  localparam int EXT_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int XE_W  = EXP_W + 1;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam int SH_W  = (LZ_W > XE_W) ? LZ_W : XE_W;
  localparam logic [XE_W-1:0] EXP_TOP = XE_W'((1 << EXP_W) - 1);

  logic [LZ_W-1:0]   lz;
  logic              lz_found;
  logic [SH_W-1:0]   sh_lz, sh_lim, sh_amt;
  logic [XE_W-1:0]   exp_x, exp_n, exp_f;
  logic [EXT_W-1:0]  ext;
  logic [MAN_W:0]    keep, sig_f;
  logic              guard_b, rest_b, rnd_up;
  logic [MAN_W+1:0]  rounded;
  logic              is_zero, sat;
  logic [EXP_W-1:0]  exp_fld;
  logic [WORD_W-1:0] mag_max;
  logic              unused_mag;

  assign unused_mag = ^mag_max;

  always_comb begin
    lz       = LZ_W'(EXT_W);
    lz_found = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!lz_found && sum_i[i]) begin
        lz       = LZ_W'(EXT_W - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // The left shift stops at exponent 1 so tiny results land as subnormals.
  always_comb begin
    exp_x  = XE_W'(exp_i);
    sh_lz  = SH_W'(lz);
    sh_lim = SH_W'(exp_x - XE_W'(1));
    sh_amt = (sh_lz < sh_lim) ? sh_lz : sh_lim;
    if (sum_i[SUM_W-1]) begin
      ext   = sum_i[SUM_W-1:1] | EXT_W'(sum_i[0]);
      exp_n = exp_x + XE_W'(1);
    end else begin
      ext   = sum_i[EXT_W-1:0] << sh_amt;
      exp_n = exp_x - XE_W'(sh_amt);
    end
  end

  always_comb begin
    keep    = ext[EXT_W-1:3];
    guard_b = ext[2];
    rest_b  = ext[1] | ext[0];
    rnd_up  = guard_b & (rest_b | keep[0]);
    rounded = {1'b0, keep} + (MAN_W+2)'(rnd_up);
    if (rounded[MAN_W+1]) begin
      sig_f = rounded[MAN_W+1:1];
      exp_f = exp_n + XE_W'(1);
    end else begin
      sig_f = rounded[MAN_W:0];
      exp_f = exp_n;
    end
  end

  // A result without the hidden bit is stored with exponent field 0.
  always_comb begin
    mag_max = max_finite(EXP_W, MAN_W);
    is_zero = (sum_i == '0);
    sat     = !is_zero && (exp_f > EXP_TOP);
    exp_fld = sig_f[MAN_W] ? exp_f[EXP_W-1:0] : EXP_W'(0);
    if (is_zero) begin
      res_o = '0;
    end else if (sat) begin
      res_o = {sign_i, mag_max[W-2:0]};
    end else begin
      res_o = {sign_i, exp_fld, sig_f[MAN_W-1:0]};
    end
    ovf_o = sat;
    unf_o = !is_zero && !sat && !sig_f[MAN_W];
    inx_o = !is_zero && (guard_b | rest_b);
  end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage minifloat add/subtract with valid/ready backpressure.
// Defining FP_ADD_FLAGS_EN adds flag_ovf/flag_unf/flag_inx outputs aligned with c.
module fp_adder_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inx
`endif
);

  localparam int SUM_W = MAN_W + 5;
  localparam logic [MAX_EXP_W-1:0] SH_CAP = MAX_EXP_W'(MAN_W + 3);

  fields_t              fa, fb;
  logic                 b_sign, a_ge_b;
  logic [MAX_MAN_W:0]   big_sig, small_sig;
  logic [MAX_EXP_W-1:0] big_exp, small_exp, exp_diff, sh_amt;
  logic [MAX_EXT_W-1:0] ext_small, lost_mask, small_al;
  logic [MAX_EXT_W:0]   sum_full;

  align_t           s1_d, s1_q;
  logic             v1_d, v1_q;
  logic             v2_d, v2_q;
  logic             s2_sign_d, s2_sign_q;
  logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
  logic [SUM_W-1:0] s2_sum_d, s2_sum_q;
  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     c_d, c_q;

  logic [W-1:0]     nr_res;
  logic             nr_ovf, nr_unf, nr_inx;
  logic             unused_hi;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign unused_hi = ^{s1_q.exp, sum_full};

  // Align: pick the larger magnitude, shift the smaller one keeping G/R/S.
  always_comb begin
    fa        = unpack(WORD_W'(a), EXP_W, MAN_W);
    fb        = unpack(WORD_W'(b), EXP_W, MAN_W);
    b_sign    = fb.sign ^ sub;
    a_ge_b    = {fa.exp_fld, fa.man_fld} >= {fb.exp_fld, fb.man_fld};
    big_sig   = a_ge_b ? fa.sig : fb.sig;
    small_sig = a_ge_b ? fb.sig : fa.sig;
    big_exp   = a_ge_b ? fa.eff_exp : fb.eff_exp;
    small_exp = a_ge_b ? fb.eff_exp : fa.eff_exp;
    exp_diff  = big_exp - small_exp;
    sh_amt    = (exp_diff > SH_CAP) ? SH_CAP : exp_diff;
    ext_small = {small_sig, 3'b000};
    lost_mask = (MAX_EXT_W'(1) << sh_amt) - MAX_EXT_W'(1);
    small_al  = (ext_small >> sh_amt) | MAX_EXT_W'(|(ext_small & lost_mask));

    s1_d = s1_q;
    v1_d = v1_q;
    if (in_ready) begin
      v1_d                = in_valid;
      s1_d.sign           = a_ge_b ? fa.sign : b_sign;
      s1_d.exp            = big_exp;
      s1_d.mant_big       = {big_sig, 3'b000};
      s1_d.mant_small_ext = small_al;
      s1_d.eff_sub        = fa.sign ^ b_sign;
    end
  end

  always_comb begin
    if (s1_q.eff_sub) begin
      sum_full = {1'b0, s1_q.mant_big} - {1'b0, s1_q.mant_small_ext};
    end else begin
      sum_full = {1'b0, s1_q.mant_big} + {1'b0, s1_q.mant_small_ext};
    end

    v2_d      = v2_q;
    s2_sign_d = s2_sign_q;
    s2_exp_d  = s2_exp_q;
    s2_sum_d  = s2_sum_q;
    if (in_ready) begin
      v2_d      = v1_q;
      s2_sign_d = s1_q.sign;
      s2_exp_d  = EXP_W'(s1_q.exp);
      s2_sum_d  = SUM_W'(sum_full);
    end
  end

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .sign_i (s2_sign_q),
    .exp_i  (s2_exp_q),
    .sum_i  (s2_sum_q),
    .res_o  (nr_res),
    .ovf_o  (nr_ovf),
    .unf_o  (nr_unf),
    .inx_o  (nr_inx)
  );

`ifdef FP_ADD_FLAGS_EN
  logic [2:0] flags_d, flags_q;
  assign {flag_ovf, flag_unf, flag_inx} = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^{nr_ovf, nr_unf, nr_inx};
`endif

  // Output register only reloads on a real result; bubbles leave c untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    c_d         = c_q;
`ifdef FP_ADD_FLAGS_EN
    flags_d     = flags_q;
`endif
    if (in_ready) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        c_d     = nr_res;
`ifdef FP_ADD_FLAGS_EN
        flags_d = {nr_ovf, nr_unf, nr_inx};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_sum_q    <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
`ifdef FP_ADD_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      s1_q        <= s1_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_sum_q    <= s2_sum_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
`ifdef FP_ADD_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe in the default E4M3 format: vector table,
// backpressure stream and mid-flight reset.
module tb_fp_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
`ifdef FP_ADD_FLAGS_EN
  logic       flag_ovf, flag_unf, flag_inx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] c;
    logic       ovf;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  fp_adder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Called #1 after a rising edge with in_ready high; returns after the accept edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vs);
    a        = va;
    b        = vb;
    sub      = vs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runVector(input int idx);
    int lat;
    applyStimulus(vecs[idx].a, vecs[idx].b, vecs[idx].sub);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("v%0d latency", idx), lat, 3);
    checkOutput($sformatf("v%0d c", idx), c, vecs[idx].c);
`ifdef FP_ADD_FLAGS_EN
    checkOutput($sformatf("v%0d flag_ovf", idx), flag_ovf, vecs[idx].ovf);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c_prev;
    logic       stalled_prev;
    int         sent;
    int         recv;

    vecs[0]  = '{8'h38, 8'h38, 1'b0, 8'h40, 1'b0};
    vecs[1]  = '{8'h38, 8'h38, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{8'h38, 8'h18, 1'b0, 8'h38, 1'b0};
    vecs[3]  = '{8'h38, 8'h19, 1'b0, 8'h39, 1'b0};
    vecs[4]  = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[6]  = '{8'h40, 8'h38, 1'b1, 8'h38, 1'b0};
    vecs[7]  = '{8'h38, 8'h40, 1'b1, 8'hB8, 1'b0};
    vecs[8]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[9]  = '{8'h07, 8'h01, 1'b0, 8'h08, 1'b0};
    vecs[10] = '{8'hC0, 8'h38, 1'b0, 8'hB8, 1'b0};
    vecs[11] = '{8'h70, 8'h08, 1'b0, 8'h70, 1'b0};
    vecs[12] = '{8'h39, 8'h18, 1'b0, 8'h3A, 1'b0};
    vecs[13] = '{8'h3F, 8'h18, 1'b0, 8'h40, 1'b0};
    vecs[14] = '{8'h39, 8'h38, 1'b1, 8'h20, 1'b0};
    vecs[15] = '{8'h09, 8'h08, 1'b1, 8'h01, 1'b0};
    vecs[16] = '{8'h40, 8'h01, 1'b1, 8'h40, 1'b0};
    vecs[17] = '{8'h77, 8'h77, 1'b0, 8'h7F, 1'b0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    #1 rst_n  = 1'b0;
    #11;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset c", c, 0);
    checkOutput("reset in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset in_ready", in_ready, 1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 18; i++) begin
      runVector(i);
    end

    // Six back-to-back pairs with the consumer stalled in cycles 4..7.
    $display("[TB] backpressure stream");
    sent         = 0;
    recv         = 0;
    stalled_prev = 1'b0;
    c_prev       = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 6) begin
        a        = vecs[sent].a;
        b        = vecs[sent].b;
        sub      = vecs[sent].sub;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkOutput($sformatf("bp in_ready cyc%0d", cyc), in_ready, !(out_valid && !out_ready));
      if (stalled_prev) begin
        checkOutput($sformatf("bp hold valid cyc%0d", cyc), out_valid, 1);
        checkOutput($sformatf("bp hold c cyc%0d", cyc), c, c_prev);
      end
      stalled_prev = out_valid && !out_ready;
      c_prev       = c;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp result %0d", recv), c, vecs[recv].c);
        recv++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp results received", recv, 6);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp no extra %0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Three accepts with the consumer stalled, then reset with two still in flight.
    $display("[TB] reset with results in flight");
    out_ready = 1'b0;
    for (int k = 6; k < 9; k++) begin
      applyStimulus(vecs[k].a, vecs[k].b, vecs[k].sub);
    end
    checkOutput("pre-reset out_valid", out_valid, 1);
    checkOutput("pre-reset c", c, vecs[6].c);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset c", c, 0);
    checkOutput("async reset in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("no stale result %0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end
    runVector(0);
    runVector(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
